// File: rtl/mem_resp_pkg.sv
// Shared types for the memory responder: FSM states and latency counter width.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY,
        RESP
    } state_t;

    localparam int LAT_W = 4;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted write buffer: synchronous FIFO holding {word index, data} store entries.
module wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 44
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    always_comb begin
        full    = (cnt_q == CW'(DEPTH));
        empty   = (cnt_q == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = wr_q + PW'(do_push);
        rd_d    = rd_q + PW'(do_pop);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        rdata   = mem_q[rd_q];
        count   = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency fetch/load responder
// over word RAM with a posted write buffer.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter int    LATENCY    = 2,
  parameter int    WBUF_DEPTH = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_iaddr,
  input  logic        i_iread_en,
  output logic [31:0] o_inst,
  output logic        o_iread_vd,
  input  logic [31:0] i_memaddr,
  input  logic        i_read_en,
  output logic [31:0] o_read_data,
  output logic        o_read_vd,
  input  logic        i_write_en,
  input  logic [31:0] i_write_data,
  output logic        o_exstall
);

  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int ENT_W     = ADDR_WIDTH + 32;
  localparam int CNT_W     = $clog2(WBUF_DEPTH) + 1;
  localparam logic [LAT_W-1:0] LAT_INIT =
    LAT_W'(LATENCY - 1);

  logic [31:0] mem [RAM_DEPTH];

  state_t                state_q;
  logic [LAT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  iread_vd_q;
  logic                  read_vd_q;
  logic [31:0]           inst_q;
  logic [31:0]           read_data_q;

  logic                  wb_push;
  logic                  wb_pop;
  logic                  wb_full;
  logic                  wb_empty;
  logic [ENT_W-1:0]      wb_wdata;
  logic [ENT_W-1:0]      wb_rdata;
  logic [CNT_W-1:0]      wb_count;
  logic [ADDR_WIDTH-1:0] i_idx;
  logic [ADDR_WIDTH-1:0] d_idx;
  logic [ADDR_WIDTH-1:0] drain_idx;
  logic [31:0]           drain_data;
  logic                  unused_bits;

  assign unused_bits = ^{wb_count,
    i_iaddr[31:ADDR_WIDTH+2], i_iaddr[1:0],
    i_memaddr[31:ADDR_WIDTH+2], i_memaddr[1:0]};

  always_comb begin
    i_idx      = i_iaddr[ADDR_WIDTH+1:2];
    d_idx      = i_memaddr[ADDR_WIDTH+1:2];
    wb_push    = i_write_en;
    wb_pop     = (state_q == IDLE) && !wb_empty;
    wb_wdata   = {d_idx, i_write_data};
    drain_idx  = wb_rdata[ENT_W-1:32];
    drain_data = wb_rdata[31:0];
    o_exstall  = i_write_en && wb_full;
  end

  wbuf_fifo #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH (ENT_W)
  ) u_wbuf (
    .clk   (clk),
    .rst   (rst),
    .push  (wb_push),
    .pop   (wb_pop),
    .wdata (wb_wdata),
    .rdata (wb_rdata),
    .full  (wb_full),
    .empty (wb_empty),
    .count (wb_count)
  );

  always_ff @(posedge clk) begin
    if (wb_pop) begin
      mem[drain_idx] <= drain_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      iread_vd_q  <= 1'b0;
      read_vd_q   <= 1'b0;
      inst_q      <= '0;
      read_data_q <= '0;
    end else begin
      iread_vd_q <= 1'b0;
      read_vd_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (wb_empty) begin
            if (i_read_en) begin
              idx_q   <= d_idx;
              cnt_q   <= LAT_INIT;
              state_q <= DBUSY;
            end else if (i_iread_en) begin
              idx_q   <= i_idx;
              cnt_q   <= LAT_INIT;
              state_q <= IBUSY;
            end
          end
        end
        IBUSY, DBUSY: begin
          if (cnt_q == '0) begin
            if (state_q == IBUSY) begin
              inst_q     <= mem[idx_q];
              iread_vd_q <= 1'b1;
            end else begin
              read_data_q <= mem[idx_q];
              read_vd_q   <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_inst      = inst_q;
  assign o_iread_vd  = iread_vd_q;
  assign o_read_data = read_data_q;
  assign o_read_vd   = read_vd_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: main instance at LATENCY=2 plus
// LATENCY=1 and LATENCY=15 instances sharing the same stimulus.
module tb_mem_responder;

    localparam int LAT = 2;

    typedef struct {
        bit          is_load;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_iaddr, i_memaddr, i_write_data;
    logic        i_iread_en, i_read_en, i_write_en;
    logic [31:0] o_inst, o_read_data;
    logic        o_iread_vd, o_read_vd, o_exstall;
    logic [31:0] inst1, rdata1, inst15, rdata15;
    logic        ivd1, rvd1, stall1, ivd15, rvd15, stall15;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   pulse_cnt = 0;
    int   p1_cyc = -1;
    int   p15_cyc = -1;
    exp_t sb[$];

    mem_responder #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_iaddr(i_iaddr), .i_iread_en(i_iread_en),
        .o_inst(o_inst), .o_iread_vd(o_iread_vd),
        .i_memaddr(i_memaddr), .i_read_en(i_read_en),
        .o_read_data(o_read_data), .o_read_vd(o_read_vd),
        .i_write_en(i_write_en), .i_write_data(i_write_data),
        .o_exstall(o_exstall)
    );

    mem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_iaddr(i_iaddr), .i_iread_en(i_iread_en),
        .o_inst(inst1), .o_iread_vd(ivd1),
        .i_memaddr(i_memaddr), .i_read_en(i_read_en),
        .o_read_data(rdata1), .o_read_vd(rvd1),
        .i_write_en(i_write_en), .i_write_data(i_write_data),
        .o_exstall(stall1)
    );

    mem_responder #(.LATENCY(15)) dut15 (
        .clk(clk), .rst(rst),
        .i_iaddr(i_iaddr), .i_iread_en(i_iread_en),
        .o_inst(inst15), .o_iread_vd(ivd15),
        .i_memaddr(i_memaddr), .i_read_en(i_read_en),
        .o_read_data(rdata15), .o_read_vd(rvd15),
        .i_write_en(i_write_en), .i_write_data(i_write_data),
        .o_exstall(stall15)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        exp_t        e;
        logic [31:0] d;
        if (o_iread_vd || o_read_vd) begin
            pulse_cnt++;
            n_chk++;
            d = o_read_vd ? o_read_data : o_inst;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pulse: cyc %0d ivd=%b rvd=%b data=%h, required no pulse",
                         cyc, o_iread_vd, o_read_vd, d);
            end else begin
                e = sb.pop_front();
                if ((o_iread_vd && o_read_vd) || (o_read_vd !== e.is_load) ||
                    (d !== e.data) || (cyc != e.cyc))
                    $display("FAIL response: got load=%b data=%h cyc=%0d, required load=%b data=%h cyc=%0d",
                             o_read_vd, d, cyc, e.is_load, e.data, e.cyc);
                else
                    n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        if (ivd1) p1_cyc = cyc;
        if (ivd15) p15_cyc = cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_sb(input int n, output bit ok);
        for (int i = 0; i < n && sb.size() != 0; i++) tick();
        ok = (sb.size() == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_write_en = 1'b1;
        tick();
        tick();
        n_chk++;
        if (o_iread_vd !== 1'b0) $display("FAIL reset_ivd: got %b, required 0", o_iread_vd);
        else n_pass++;
        n_chk++;
        if (o_read_vd !== 1'b0) $display("FAIL reset_rvd: got %b, required 0", o_read_vd);
        else n_pass++;
        n_chk++;
        if (o_inst !== 32'h0) $display("FAIL reset_inst: got %h, required 0", o_inst);
        else n_pass++;
        n_chk++;
        if (o_read_data !== 32'h0) $display("FAIL reset_rdata: got %h, required 0", o_read_data);
        else n_pass++;
        n_chk++;
        if (o_exstall !== 1'b0) $display("FAIL reset_exstall: got %b, required 0", o_exstall);
        else n_pass++;
        i_write_en = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        bit ok;
        i_memaddr = 32'h40;
        i_write_data = 32'hDEADBEEF;
        i_write_en = 1'b1;
        tick();
        i_write_en = 1'b0;
        tick();
        tick();
        i_iaddr = 32'h40;
        i_iread_en = 1'b1;
        sb.push_back('{is_load: 1'b0, data: 32'hDEADBEEF, cyc: cyc + 1 + LAT});
        tick();
        i_iread_en = 1'b0;
        drain_sb(20, ok);
        n_chk++;
        if (!ok) $display("FAIL fetch_timeout: got %0d pending, required 0", sb.size());
        else n_pass++;
        tick();
        tick();
        n_chk++;
        if (o_inst !== 32'hDEADBEEF || o_iread_vd !== 1'b0)
            $display("FAIL fetch_hold: got inst=%h vd=%b, required DEADBEEF/0", o_inst, o_iread_vd);
        else n_pass++;
    endtask

    task automatic test_latency();
        bit ok;
        int t;
        repeat (20) tick();
        p1_cyc = -1;
        p15_cyc = -1;
        i_iaddr = 32'h40;
        i_iread_en = 1'b1;
        t = cyc;
        sb.push_back('{is_load: 1'b0, data: 32'hDEADBEEF, cyc: t + 1 + LAT});
        tick();
        i_iread_en = 1'b0;
        for (int i = 0; i < 30 && p15_cyc < 0; i++) tick();
        n_chk++;
        if (p1_cyc != t + 2) $display("FAIL lat1_cycle: got %0d, required %0d", p1_cyc, t + 2);
        else n_pass++;
        n_chk++;
        if (p15_cyc != t + 16) $display("FAIL lat15_cycle: got %0d, required %0d", p15_cyc, t + 16);
        else n_pass++;
        n_chk++;
        if (inst1 !== 32'hDEADBEEF) $display("FAIL lat1_data: got %h, required DEADBEEF", inst1);
        else n_pass++;
        n_chk++;
        if (inst15 !== 32'hDEADBEEF) $display("FAIL lat15_data: got %h, required DEADBEEF", inst15);
        else n_pass++;
        drain_sb(20, ok);
        n_chk++;
        if (!ok) $display("FAIL lat_main_timeout: got %0d pending, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_store_load();
        bit ok;
        i_memaddr = 32'h100;
        i_write_data = 32'h12345678;
        i_write_en = 1'b1;
        tick();
        i_write_en = 1'b0;
        i_read_en = 1'b1;
        sb.push_back('{is_load: 1'b1, data: 32'h12345678, cyc: cyc + 2 + LAT});
        tick();
        tick();
        i_read_en = 1'b0;
        drain_sb(20, ok);
        n_chk++;
        if (!ok) $display("FAIL store_load_timeout: got %0d pending, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_simul();
        bit ok;
        i_memaddr = 32'h100;
        i_iaddr = 32'h40;
        i_read_en = 1'b1;
        i_iread_en = 1'b1;
        sb.push_back('{is_load: 1'b1, data: 32'h12345678, cyc: cyc + 1 + LAT});
        sb.push_back('{is_load: 1'b0, data: 32'hDEADBEEF, cyc: cyc + 3 + 2 * LAT});
        tick();
        i_read_en = 1'b0;
        repeat (LAT + 2) tick();
        i_iread_en = 1'b0;
        drain_sb(30, ok);
        n_chk++;
        if (!ok) $display("FAIL simul_timeout: got %0d pending, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int r;
        int stalls = 0;
        int stall_cyc = -1;
        i_iaddr = 32'h40;
        i_iread_en = 1'b1;
        r = cyc;
        sb.push_back('{is_load: 1'b0, data: 32'hDEADBEEF, cyc: r + 1 + LAT});
        for (int i = 0; i < 5; i++) begin
            i_memaddr = 32'h200 + 32'(4 * i);
            i_write_data = 32'hA5000000 + 32'(i);
            i_write_en = 1'b1;
            for (int g = 0; g < 20 && o_exstall; g++) begin
                if (stall_cyc < 0) stall_cyc = cyc;
                stalls++;
                tick();
            end
            tick();
            if (i == 0) i_iread_en = 1'b0;
        end
        i_write_en = 1'b0;
        n_chk++;
        if (stalls != LAT - 1) $display("FAIL b2b_stall_len: got %0d, required %0d", stalls, LAT - 1);
        else n_pass++;
        n_chk++;
        if (stall_cyc != r + 4) $display("FAIL b2b_stall_cyc: got %0d, required %0d", stall_cyc, r + 4);
        else n_pass++;
        repeat (10) tick();
        n_chk++;
        if (sb.size() != 0) $display("FAIL b2b_fetch_timeout: got %0d pending, required 0", sb.size());
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            i_memaddr = 32'h200 + 32'(4 * i);
            i_read_en = 1'b1;
            sb.push_back('{is_load: 1'b1, data: 32'hA5000000 + 32'(i), cyc: cyc + 1 + LAT});
            tick();
            i_read_en = 1'b0;
            drain_sb(20, ok);
            n_chk++;
            if (!ok) $display("FAIL b2b_load_timeout: entry %0d got %0d pending, required 0", i, sb.size());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int p;
        i_memaddr = 32'h300;
        i_write_data = 32'h11110000;
        i_write_en = 1'b1;
        tick();
        i_write_en = 1'b0;
        repeat (3) tick();
        i_memaddr = 32'h100;
        i_read_en = 1'b1;
        tick();
        i_read_en = 1'b0;
        i_memaddr = 32'h300;
        i_write_data = 32'hCAFEF00D;
        i_write_en = 1'b1;
        tick();
        i_write_en = 1'b0;
        p = pulse_cnt;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        n_chk++;
        if (pulse_cnt != p) $display("FAIL rst_mid_pulse: got %0d pulses, required 0", pulse_cnt - p);
        else n_pass++;
        i_memaddr = 32'h300;
        i_read_en = 1'b1;
        sb.push_back('{is_load: 1'b1, data: 32'h11110000, cyc: cyc + 1 + LAT});
        tick();
        i_read_en = 1'b0;
        drain_sb(20, ok);
        n_chk++;
        if (!ok) $display("FAIL rst_mid_load300_timeout: got %0d pending, required 0", sb.size());
        else n_pass++;
        i_memaddr = 32'h100;
        i_read_en = 1'b1;
        sb.push_back('{is_load: 1'b1, data: 32'h12345678, cyc: cyc + 1 + LAT});
        tick();
        i_read_en = 1'b0;
        drain_sb(20, ok);
        n_chk++;
        if (!ok) $display("FAIL rst_mid_load100_timeout: got %0d pending, required 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        i_iaddr = '0;
        i_memaddr = '0;
        i_write_data = '0;
        i_iread_en = 1'b0;
        i_read_en = 1'b0;
        i_write_en = 1'b0;
        test_reset();
        test_fetch();
        test_latency();
        test_store_load();
        test_simul();
        test_back_to_back();
        test_reset_mid();
        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
